// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared defaults and FSM encoding for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  localparam int IN_W_DEF    = 14;
  localparam int DIGITS_DEF  = 4;
  localparam int MAX_VAL_DEF = 9999;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  always_comb begin
    adj = digit;
    if (digit >= 4'd5) begin
      adj = digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one iteration per clock, saturating to
// all nines when the operand exceeds MAX_VAL.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int DIGITS  = DIGITS_DEF,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       binIn,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcdOut
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + IN_W;

  localparam logic [31:0]       MAX_VAL_U = 32'(MAX_VAL);
  localparam logic [IN_W-1:0]   CNT_LAST  = IN_W'(IN_W - 1);
  localparam logic [IN_W-1:0]   CNT_ONE   = IN_W'(1);
  localparam logic [BCD_W-1:0]  ALL_NINES = {DIGITS{4'h9}};

  logic [1:0]        state_reg;
  logic [IN_W-1:0]   cnt_reg;
  logic [WORK_W-1:0] work_reg;
  logic              ovf_pend_reg;
  logic              done_reg;
  logic              overflow_reg;
  logic [BCD_W-1:0]  bcd_out_reg;

  logic [BCD_W-1:0]  adj_bcd;
  logic [WORK_W-1:0] adj_work;
  logic [WORK_W-1:0] shift_next;

  // One corrector per digit of the working BCD field, which sits above the binary field.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit (work_reg[IN_W + 4*gi +: 4]),
        .adj   (adj_bcd[4*gi +: 4])
      );
    end
  endgenerate

  assign adj_work   = {adj_bcd, work_reg[IN_W-1:0]};
  assign shift_next = {adj_work[WORK_W-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      work_reg     <= '0;
      ovf_pend_reg <= 1'b0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      bcd_out_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            work_reg <= {{BCD_W{1'b0}}, binIn};
            cnt_reg  <= '0;
            // Out-of-range operands bypass the shift loop entirely.
            if (32'(binIn) > MAX_VAL_U) begin
              ovf_pend_reg <= 1'b1;
              state_reg    <= ST_FINISH;
            end else begin
              ovf_pend_reg <= 1'b0;
              state_reg    <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          work_reg <= shift_next;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= ST_FINISH;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        ST_FINISH: begin
          bcd_out_reg  <= ovf_pend_reg ? ALL_NINES : work_reg[WORK_W-1:IN_W];
          overflow_reg <= ovf_pend_reg;
          done_reg     <= 1'b1;
          state_reg    <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign overflow = overflow_reg;
  assign bcdOut   = bcd_out_reg;

endmodule
